// File: rtl/branch_cond_unit_if.sv
// ----------------------------------------------------------------------------
// branch_cond_unit_if
//   Bundles the two valid/ready channels of the branch condition unit.
//   The request side carries one branch op. The response side returns the
//   resolved branch.
//
//   Request  : in_valid, in_ready, funct3, rs1, rs2, pc, imm
//   Response : out_valid, out_ready, taken, next_pc, misaligned, illegal
//
//   master : issues branch ops and consumes results (decode / fetch side)
//   slave  : the branch condition unit
// ----------------------------------------------------------------------------
interface branch_cond_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;

    logic            out_valid;
    logic            out_ready;
    logic            taken;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;
    logic            illegal;

    modport master (
        output in_valid, funct3, rs1, rs2, pc, imm, out_ready,
        input  in_ready, out_valid, taken, next_pc, misaligned, illegal
    );

    modport slave (
        input  in_valid, funct3, rs1, rs2, pc, imm, out_ready,
        output in_ready, out_valid, taken, next_pc, misaligned, illegal
    );
endinterface

// File: rtl/branch_cond_unit.sv
// ----------------------------------------------------------------------------
// branch_cond_unit
//   Multi-cycle RISC-V branch resolver. It accepts one op when idle. It then
//   compares rs1 and rs2 MSB-first, CHUNK bits per cycle, and stops at the
//   first chunk that differs. The result is held on the response channel
//   until the consumer takes it.
//
//   Ports
//     clk  : rising-edge clock
//     rst  : asynchronous, active-high reset; it drops any op in flight
//     bus  : branch_cond_unit_if.slave (request and response channels)
//
//   Parameters
//     XLEN  : operand / PC width
//     CHUNK : bits compared per cycle. XLEN must be a multiple of CHUNK.
// ----------------------------------------------------------------------------
module branch_cond_unit #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic                clk,
    input  logic                rst,
    branch_cond_unit_if.slave   bus
);

    localparam int N     = XLEN / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMP,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // The operands are stored as an array of chunks, so the active chunk is
    // selected with a plain index.
    logic [N-1:0][CHUNK-1:0] r_a;
    logic [N-1:0][CHUNK-1:0] r_b;
    logic [2:0]              r_funct3;
    logic [XLEN-1:0]         r_pc_imm;
    logic [XLEN-1:0]         r_pc_4;
    logic [IDX_W-1:0]        r_idx;

    logic                    r_taken;
    logic [XLEN-1:0]         r_next_pc;
    logic                    r_misaligned;
    logic                    r_illegal;
    logic                    r_out_valid;

    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_in_illegal;
    logic                    w_in_signed;
    logic [XLEN-1:0]         w_sign_flip;
    logic [CHUNK-1:0]        w_chunk_a;
    logic [CHUNK-1:0]        w_chunk_b;
    logic                    w_chunk_ne;
    logic                    w_lt;
    logic                    w_eq;
    logic                    w_cmp_done;
    logic                    w_cond;

    // funct3 values 010 and 011 are not branches.
    assign w_in_illegal = (bus.funct3[2:1] == 2'b01);
    // BLT/BGE (10x) are signed.
    assign w_in_signed  = (bus.funct3[2:1] == 2'b10);

    // Flipping the sign bit of both operands maps two's complement onto an
    // order-preserving unsigned range. After that, every chunk is compared
    // as unsigned. Equality is not affected.
    assign w_sign_flip  = {w_in_signed, {(XLEN-1){1'b0}}};

    assign w_chunk_a  = r_a[r_idx];
    assign w_chunk_b  = r_b[r_idx];
    assign w_chunk_ne = (w_chunk_a != w_chunk_b);
    // lt and eq are only consumed when w_cmp_done is set. At that point
    // either this chunk decides the result, or every chunk was equal.
    assign w_lt       = w_chunk_ne && (w_chunk_a < w_chunk_b);
    assign w_eq       = !w_chunk_ne;
    assign w_cmp_done = w_chunk_ne || (r_idx == '0);

    always_comb begin
        w_cond = 1'b0;
        case (r_funct3)
            3'b000:         w_cond = w_eq;   // BEQ
            3'b001:         w_cond = !w_eq;  // BNE
            3'b100, 3'b110: w_cond = w_lt;   // BLT, BLTU
            3'b101, 3'b111: w_cond = !w_lt;  // BGE, BGEU
            default:        w_cond = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: each process reads the previous-cycle values of its neighbours
    // because every register here is updated with <=.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: all outputs get a default before the case statement, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next_state = w_in_illegal ? S_DONE : S_CMP;
                end
            end
            S_CMP: begin
                if (w_cmp_done) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (r_out_valid && bus.out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_accept = w_in_ready && bus.in_valid;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_funct3     <= '0;
            r_pc_imm     <= '0;
            r_pc_4       <= '0;
            r_idx        <= '0;
            r_taken      <= 1'b0;
            r_next_pc    <= '0;
            r_misaligned <= 1'b0;
            r_illegal    <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a       <= bus.rs1 ^ w_sign_flip;
                        r_b       <= bus.rs2 ^ w_sign_flip;
                        r_funct3  <= bus.funct3;
                        r_pc_imm  <= bus.pc + bus.imm;
                        r_pc_4    <= bus.pc + XLEN'(4);
                        r_idx     <= IDX_W'(N - 1);
                        r_illegal <= w_in_illegal;
                        // An illegal op skips the compare, so its result is
                        // fixed here.
                        if (w_in_illegal) begin
                            r_taken      <= 1'b0;
                            r_next_pc    <= bus.pc + XLEN'(4);
                            r_misaligned <= 1'b0;
                        end
                    end
                end
                S_CMP: begin
                    if (w_cmp_done) begin
                        r_taken      <= w_cond;
                        r_next_pc    <= w_cond ? r_pc_imm : r_pc_4;
                        r_misaligned <= w_cond && (r_pc_imm[1:0] != 2'b00);
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                S_DONE: begin
                    // out_valid rises one edge after entering DONE. It falls
                    // on the edge that completes the handshake, which is the
                    // same edge on which the state returns to IDLE.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.taken      = r_taken;
    assign bus.next_pc    = r_next_pc;
    assign bus.misaligned = r_misaligned;
    assign bus.illegal    = r_illegal;

endmodule

// File: tb/tb_branch_cond_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_cond_unit
//   Directed vectors with hand-computed results for branch_cond_unit
//   (XLEN=32, CHUNK=8). Latency is counted in rising edges after the accept
//   edge.
// ----------------------------------------------------------------------------
module tb_branch_cond_unit;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    branch_cond_unit_if #(.XLEN(XLEN)) bus ();

    branch_cond_unit #(
        .XLEN  (XLEN),
        .CHUNK (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op, measure the latency, check the result, optionally hold
    // out_ready low for 'hold' cycles, then complete the handshake.
    task automatic run_op(
        input string       name,
        input logic [2:0]  f3,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] pc,
        input logic [31:0] imm,
        input int          exp_lat,
        input logic        exp_taken,
        input logic [31:0] exp_npc,
        input logic        exp_mis,
        input logic        exp_ill,
        input int          hold
    );
        int lat;
        @(negedge clk);
        check({name, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
        bus.funct3   = f3;
        bus.rs1      = a;
        bus.rs2      = b;
        bus.pc       = pc;
        bus.imm      = imm;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        // Scramble the inputs after the accept edge. The unit must ignore them.
        bus.in_valid = 1'b0;
        bus.rs1      = ~a;
        bus.rs2      = a;
        bus.pc       = 32'hDEAD_BEEF;
        bus.imm      = 32'h0000_0001;
        bus.funct3   = ~f3;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " latency"},    32'(lat),            32'(exp_lat));
        check({name, " taken"},      32'(bus.taken),      32'(exp_taken));
        check({name, " next_pc"},    bus.next_pc,         exp_npc);
        check({name, " misaligned"}, 32'(bus.misaligned), 32'(exp_mis));
        check({name, " illegal"},    32'(bus.illegal),    32'(exp_ill));
        check({name, " in_ready busy"}, 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({name, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
            check({name, " hold taken"},     32'(bus.taken),     32'(exp_taken));
            check({name, " hold next_pc"},   bus.next_pc,        exp_npc);
            check({name, " hold in_ready"},  32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({name, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
        check({name, " in_ready back"},  32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.funct3    = 3'b000;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.pc        = '0;
        bus.imm       = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready",   32'(bus.in_ready),   32'd1);
        check("reset out_valid",  32'(bus.out_valid),  32'd0);
        check("reset taken",      32'(bus.taken),      32'd0);
        check("reset next_pc",    bus.next_pc,         32'd0);
        check("reset misaligned", 32'(bus.misaligned), 32'd0);
        check("reset illegal",    32'(bus.illegal),    32'd0);
        @(negedge clk);
        rst = 1'b0;

        //      name         f3      rs1           rs2           pc            imm           lat tk  next_pc       mis ill hold
        run_op("beq_eq",    3'b000, 32'h12345678, 32'h12345678, 32'h00000100, 32'h00000020, 5, 1'b1, 32'h00000120, 1'b0, 1'b0, 0);
        run_op("blt_neg",   3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h00000200, 32'h00000040, 2, 1'b1, 32'h00000240, 1'b0, 1'b0, 0);
        run_op("bltu_big",  3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h00000200, 32'h00000040, 2, 1'b0, 32'h00000204, 1'b0, 1'b0, 0);
        run_op("bgeu_c1",   3'b111, 32'h00000100, 32'h000000FF, 32'h00000300, 32'hFFFFFFF8, 4, 1'b1, 32'h000002F8, 1'b0, 1'b0, 0);
        run_op("bge_eq",    3'b101, 32'h80000000, 32'h80000000, 32'h00000400, 32'h00000010, 5, 1'b1, 32'h00000410, 1'b0, 1'b0, 0);
        run_op("illegal",   3'b010, 32'h00000001, 32'h00000002, 32'h00000500, 32'h00000010, 1, 1'b0, 32'h00000504, 1'b0, 1'b1, 0);
        run_op("illegal3",  3'b011, 32'h00000000, 32'h00000000, 32'h00000508, 32'h00000010, 1, 1'b0, 32'h0000050C, 1'b0, 1'b1, 0);
        run_op("bne_mis",   3'b001, 32'h00000001, 32'h00000002, 32'h00000600, 32'h00000002, 5, 1'b1, 32'h00000602, 1'b1, 1'b0, 0);
        run_op("blt_pos",   3'b100, 32'h00000005, 32'hFFFFFFF0, 32'h00000700, 32'h00000100, 2, 1'b0, 32'h00000704, 1'b0, 1'b0, 0);
        run_op("bltu_c1",   3'b110, 32'h12345600, 32'h12345700, 32'h00000800, 32'h00000024, 4, 1'b1, 32'h00000824, 1'b0, 1'b0, 0);
        run_op("bne_eq",    3'b001, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000900, 32'h00000040, 5, 1'b0, 32'h00000904, 1'b0, 1'b0, 0);
        run_op("hold",      3'b000, 32'h00000000, 32'h00000000, 32'h00000A00, 32'h00000008, 5, 1'b1, 32'h00000A08, 1'b0, 1'b0, 3);
        // Issued on the cycle right after the previous handshake.
        run_op("after_hold",3'b111, 32'h00000000, 32'h00000001, 32'h00000B00, 32'h00000008, 5, 1'b0, 32'h00000B04, 1'b0, 1'b0, 0);
        run_op("wrap",      3'b000, 32'h00000007, 32'h00000007, 32'hFFFFFFFC, 32'h00000008, 5, 1'b1, 32'h00000004, 1'b0, 1'b0, 0);

        // Reset in the middle of a compare.
        @(negedge clk);
        bus.funct3   = 3'b000;
        bus.rs1      = 32'h55555555;
        bus.rs2      = 32'h55555555;
        bus.pc       = 32'h00000C00;
        bus.imm      = 32'h00000010;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midcmp in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("rst in_ready",  32'(bus.in_ready),  32'd1);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst taken",     32'(bus.taken),     32'd0);
        check("rst next_pc",   bus.next_pc,        32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("post_rst out_valid", 32'(bus.out_valid), 32'd0);
        end

        run_op("post_rst",  3'b100, 32'h00000003, 32'h00000004, 32'h00000D00, 32'h00000010, 5, 1'b1, 32'h00000D10, 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
